// File: rtl/mmcm_seq_pkg.sv
// Shared types and constants for the MMCM lock sequencer and its status decoders.
package mmcm_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAIL      = 3'd4
  } mmcm_seq_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmcm_lock_sequencer_if.sv
// Control/status bundle between the MMCM lock sequencer (master) and its environment (slave).
interface mmcm_lock_sequencer_if
  import mmcm_seq_pkg::*;
#(
  parameter int unsigned NUM_MMCM  = 2,
  parameter int unsigned MAX_RETRY = 7,
  parameter int unsigned LOST_W    = 8
);
  logic [NUM_MMCM-1:0]             locked_i;
  logic                            restart_i;
  logic                            lost_clr_i;
  logic                            mmcm_rst_o;
  logic                            ready_o;
  logic                            fail_o;
  logic [STATE_W-1:0]              state_o;
  logic [cnt_w(MAX_RETRY+1)-1:0]   retry_cnt_o;
  logic [LOST_W-1:0]               lost_cnt_o;
  logic [NUM_MMCM-1:0]             lost_flags_o;

  modport master (
    input  locked_i, restart_i, lost_clr_i,
    output mmcm_rst_o, ready_o, fail_o, state_o, retry_cnt_o, lost_cnt_o, lost_flags_o
  );

  modport slave (
    output locked_i, restart_i, lost_clr_i,
    input  mmcm_rst_o, ready_o, fail_o, state_o, retry_cnt_o, lost_cnt_o, lost_flags_o
  );
endinterface

// File: rtl/mmcm_seq_sync.sv
// Two-stage synchroniser for the raw MMCM LOCKED bits.
module mmcm_seq_sync #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta_q;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/mmcm_lock_sequencer.sv
// MMCM reset/lock supervisor: reset pulse, lock wait with bounded retries, stability qualify.
// Optional sticky per-MMCM lock-loss flags built only when MMCM_SEQ_STICKY_EN is defined.
module mmcm_lock_sequencer
  import mmcm_seq_pkg::*;
#(
  parameter int unsigned NUM_MMCM      = 2,
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 7,
  parameter int unsigned LOST_W        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  mmcm_lock_sequencer_if.master bus
);
  localparam int unsigned TW = cnt_w(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
  localparam int unsigned RW = cnt_w(MAX_RETRY + 1);

  logic [NUM_MMCM-1:0] lk_s;
  logic                all_locked;

  mmcm_seq_state_t state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              mmcm_rst_q, ready_q, fail_q;

  mmcm_seq_sync #(.WIDTH(NUM_MMCM)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (bus.locked_i),
    .q_o     (lk_s)
  );

  assign all_locked = &lk_s;

  // One shared timer: counts cycles spent in the current RESET/WAIT_LOCK/STABLE phase.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    retry_d = retry_q;
    lost_d  = lost_q;
    if (bus.restart_i) begin
      state_d = ST_RESET;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          if (timer_q == TW'(RESET_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (all_locked) begin
            state_d = ST_STABLE;
            timer_d = '0;
          end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            timer_d = '0;
            if (retry_q == RW'(MAX_RETRY)) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = ST_RESET;
            end
          end
        end
        ST_STABLE: begin
          if (!all_locked) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
            state_d = ST_READY;
            timer_d = '0;
          end
        end
        ST_READY: begin
          timer_d = '0;
          if (!all_locked) begin
            state_d = ST_RESET;
            if (lost_q != '1) lost_d = lost_q + 1'b1;
          end
        end
        ST_FAIL: timer_d = '0;
        default: begin
          state_d = ST_RESET;
          timer_d = '0;
        end
      endcase
    end
  end

  // Output flops decode the next state so they change on the same edge as state_q.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RESET;
      timer_q    <= '0;
      retry_q    <= '0;
      lost_q     <= '0;
      mmcm_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      lost_q     <= lost_d;
      mmcm_rst_q <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      ready_q    <= (state_d == ST_READY);
      fail_q     <= (state_d == ST_FAIL);
    end
  end

  assign bus.state_o     = state_q;
  assign bus.mmcm_rst_o  = mmcm_rst_q;
  assign bus.ready_o     = ready_q;
  assign bus.fail_o      = fail_q;
  assign bus.retry_cnt_o = retry_q;
  assign bus.lost_cnt_o  = lost_q;

`ifdef MMCM_SEQ_STICKY_EN
  logic [NUM_MMCM-1:0] lk_prev_q, flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (bus.lost_clr_i) flags_d = '0;
    if ((state_q == ST_STABLE) || (state_q == ST_READY)) flags_d = flags_d | (lk_prev_q & ~lk_s);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lk_prev_q <= '0;
      flags_q   <= '0;
    end else begin
      lk_prev_q <= lk_s;
      flags_q   <= flags_d;
    end
  end

  assign bus.lost_flags_o = flags_q;
`else
  assign bus.lost_flags_o = '0;
`endif
endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Self-checking bench for mmcm_lock_sequencer: cycle model plus directed literal checks.
module tb_mmcm_lock_sequencer;
  localparam int unsigned N = 2, RC = 16, LT = 64, SC = 1024, MR = 2, LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  mmcm_lock_sequencer_if #(.NUM_MMCM(N), .MAX_RETRY(MR), .LOST_W(LW)) bus ();
  mmcm_lock_sequencer_if #(.NUM_MMCM(N), .MAX_RETRY(1), .LOST_W(8)) bus2 ();

  mmcm_lock_sequencer #(.NUM_MMCM(N), .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(SC), .MAX_RETRY(MR), .LOST_W(LW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  mmcm_lock_sequencer #(.NUM_MMCM(N), .RESET_CYCLES(2), .LOCK_TIMEOUT(16),
    .STABLE_CYCLES(2), .MAX_RETRY(1), .LOST_W(8)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: phase codes 0 RESET, 1 WAIT_LOCK, 2 STABLE, 3 READY, 4 FAIL; m_t = cycles spent in phase.
  int m_state = 0, m_t = 0, m_retry = 0, m_lost = 0;
  logic [N-1:0] m_flags = '0, s1 = '0, s2 = '0, sprev = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_t <= 0; m_retry <= 0; m_lost <= 0;
      m_flags <= '0; s1 <= '0; s2 <= '0; sprev <= '0;
    end else begin : step
      int ns, nt, nr, nl;
      logic all_lk;
      logic [N-1:0] nf;
      all_lk = (s2 == 2'b11);
      ns = m_state; nt = m_t + 1; nr = m_retry; nl = m_lost;
      if (bus.restart_i) begin
        ns = 0; nt = 0; nr = 0;
      end else if (m_state == 0) begin
        if (m_t + 1 >= int'(RC)) begin ns = 1; nt = 0; end
      end else if (m_state == 1) begin
        if (all_lk) begin ns = 2; nt = 0; end
        else if (m_t + 1 >= int'(LT)) begin
          nt = 0;
          if (m_retry >= int'(MR)) ns = 4;
          else begin nr = m_retry + 1; ns = 0; end
        end
      end else if (m_state == 2) begin
        if (!all_lk) begin ns = 1; nt = 0; end
        else if (m_t + 1 >= int'(SC)) begin ns = 3; nt = 0; end
      end else if (m_state == 3) begin
        if (!all_lk) begin ns = 0; nt = 0; nl = (m_lost < 255) ? m_lost + 1 : 255; end
      end
`ifdef MMCM_SEQ_STICKY_EN
      nf = m_flags;
      if (bus.lost_clr_i) nf = '0;
      if (m_state == 2 || m_state == 3) nf = nf | (sprev & ~s2);
`else
      nf = '0;
`endif
      m_state <= ns; m_t <= nt; m_retry <= nr; m_lost <= nl; m_flags <= nf;
      sprev <= s2; s2 <= s1; s1 <= bus.locked_i;
    end
  end

  always @(posedge clk) begin
    logic [17:0] act, exp;
    #1;
    act = {bus.state_o, bus.mmcm_rst_o, bus.ready_o, bus.fail_o,
           bus.retry_cnt_o, bus.lost_cnt_o, bus.lost_flags_o};
    exp = {3'(m_state), (m_state == 0 || m_state == 4), (m_state == 3), (m_state == 4),
           2'(m_retry), 8'(m_lost), m_flags};
    check("cycle_model", 32'(act), 32'(exp));
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, entries, prev;
    bus.locked_i = 2'b11; bus.restart_i = 1'b0; bus.lost_clr_i = 1'b0;
    bus2.locked_i = 2'b00; bus2.restart_i = 1'b0; bus2.lost_clr_i = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({bus.state_o, bus.mmcm_rst_o, bus.ready_o, bus.fail_o}), 32'h04);
    check("reset_counters", 32'({bus.retry_cnt_o, bus.lost_cnt_o, bus.lost_flags_o}), 32'h0);

    // Power-up with all locks present
    rst_n = 1'b1;
    k = 0;
    while (bus.mmcm_rst_o && k < 100) begin tick(); k++; end
    check("rst_pulse_len", 32'(k), 32'd16);
    while (!bus.ready_o && k < 1200) begin tick(); k++; end
    check("ready_latency", 32'(k), 32'd1041);
    check("powerup_retry", 32'(bus.retry_cnt_o), 32'd0);
    check("powerup_lost", 32'(bus.lost_cnt_o), 32'd0);

    // One-cycle drop of locked_i[1] while READY
    bus.locked_i = 2'b01; tick(); bus.locked_i = 2'b11;
    k = 1;
    while (bus.ready_o && k < 20) begin tick(); k++; end
    check("drop_fall_latency", 32'(k), 32'd3);
    check("drop_lost_cnt", 32'(bus.lost_cnt_o), 32'd1);
    check("drop_to_reset", 32'({bus.state_o, bus.mmcm_rst_o}), 32'h1);
`ifdef MMCM_SEQ_STICKY_EN
    check("sticky_set", 32'(bus.lost_flags_o), 32'h2);
`endif
    k = 0;
    while (!bus.ready_o && k < 1200) begin tick(); k++; end
    check("reseq_ready", 32'(bus.ready_o), 32'd1);
`ifdef MMCM_SEQ_STICKY_EN
    check("sticky_hold", 32'(bus.lost_flags_o), 32'h2);
`endif
    bus.lost_clr_i = 1'b1; tick(); bus.lost_clr_i = 1'b0;
    check("sticky_clear", 32'(bus.lost_flags_o), 32'h0);

    // Glitch during STABLE after 500 qualified cycles
    bus.restart_i = 1'b1; tick(); bus.restart_i = 1'b0;
    check("restart_state", 32'(bus.state_o), 32'd0);
    k = 0;
    while (bus.state_o != 3'd2 && k < 100) begin tick(); k++; end
    check("reach_stable", 32'(bus.state_o), 32'd2);
    repeat (500) tick();
    bus.locked_i = 2'b10; tick(); bus.locked_i = 2'b11;
    k = 1;
    while (bus.state_o != 3'd1 && k < 10) begin tick(); k++; end
    check("glitch_to_wait", 32'({bus.state_o, 8'(k)}), 32'h103);
    check("glitch_retry", 32'(bus.retry_cnt_o), 32'd0);
    while (!bus.ready_o && k < 1200) begin tick(); k++; end
    check("glitch_ready_latency", 32'(k), 32'd1028);
    bus.lost_clr_i = 1'b1; tick(); bus.lost_clr_i = 1'b0;

    // restart_i and lock drop seen in the same READY cycle
    bus.locked_i = 2'b00; tick(); tick();
    bus.restart_i = 1'b1; tick(); bus.restart_i = 1'b0;
    check("restart_vs_drop_state", 32'(bus.state_o), 32'd0);
    check("restart_vs_drop_lost", 32'(bus.lost_cnt_o), 32'd1);
    bus.locked_i = 2'b11;
    k = 0;
    while (!bus.ready_o && k < 1200) begin tick(); k++; end
    check("ready_after_restart", 32'(bus.ready_o), 32'd1);

    // Locks never arrive: retries then FAIL
    bus.locked_i = 2'b00; bus.restart_i = 1'b1;
    prev = 3; entries = 0; k = 0;
    tick(); bus.restart_i = 1'b0;
    if (bus.state_o == 3'd0 && prev != 0) entries++;
    prev = int'(bus.state_o);
    while (!bus.fail_o && k < 600) begin
      tick(); k++;
      if (bus.state_o == 3'd0 && prev != 0) entries++;
      prev = int'(bus.state_o);
    end
    check("reset_entries", 32'(entries), 32'd3);
    check("fail_retry", 32'(bus.retry_cnt_o), 32'd2);
    check("fail_outputs", 32'({bus.state_o, bus.mmcm_rst_o, bus.ready_o, bus.fail_o}), 32'h25);
    repeat (20) tick();
    check("fail_held", 32'({bus.state_o, bus.mmcm_rst_o, bus.fail_o}), 32'h13);
    bus.restart_i = 1'b1; tick(); bus.restart_i = 1'b0;
    check("fail_restart", 32'({bus.state_o, bus.fail_o, bus.retry_cnt_o}), 32'h0);

    // Asynchronous reset in WAIT_LOCK after one retry
    k = 0;
    while (bus.retry_cnt_o != 2'd1 && k < 300) begin tick(); k++; end
    while (bus.state_o != 3'd1 && k < 400) begin tick(); k++; end
    repeat (5) tick();
    check("pre_reset_wait", 32'({bus.state_o, bus.retry_cnt_o, bus.lost_cnt_o}), 32'h501);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({bus.state_o, bus.mmcm_rst_o, bus.ready_o, bus.fail_o}), 32'h04);
    check("async_reset_counters", 32'({bus.retry_cnt_o, bus.lost_cnt_o, bus.lost_flags_o}), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    bus.locked_i = 2'b11;

    // Saturation of the lock-loss counter on the fast instance
    bus2.locked_i = 2'b11; bus2.restart_i = 1'b1; tick(); bus2.restart_i = 1'b0;
    for (int i = 1; i <= 258; i++) begin
      k = 0;
      while (!bus2.ready_o && k < 50) begin tick(); k++; end
      if (!bus2.ready_o) begin
        check("sat_ready_wait", 32'(bus2.ready_o), 32'd1);
        break;
      end
      bus2.locked_i = 2'b10; tick(); bus2.locked_i = 2'b11;
      k = 0;
      while (bus2.ready_o && k < 10) begin tick(); k++; end
      if (i == 1)   check("sat_lost_1", 32'(bus2.lost_cnt_o), 32'd1);
      if (i == 254) check("sat_lost_254", 32'(bus2.lost_cnt_o), 32'd254);
      if (i == 255) check("sat_lost_255", 32'(bus2.lost_cnt_o), 32'd255);
      if (i == 258) check("sat_lost_hold", 32'(bus2.lost_cnt_o), 32'd255);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
